// File: rtl/microondas_pkg.sv
// rtl/microondas_pkg.sv - shared types and constants for the microwave countdown timer
package microondas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SET,
        ST_RUN
    } estado_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_RELOAD_TENS = 4'd5;
    localparam bcd_t SEC_RELOAD_ONES = 4'd9;

endpackage

// File: rtl/gerador_tick.sv
// rtl/gerador_tick.sv - one-second prescaler with enable, synchronous clear and a one-cycle tick
module gerador_tick #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICKS_PER_SEC);
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = en && !clr && (count_q == LAST);

    // Holding while disabled keeps sub-second progress across a pause.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/temporizador_microondas.sv
// rtl/temporizador_microondas.sv - MM:SS BCD cook timer; end-of-cook alarm built with TEMPORIZADOR_BEEP_EN
module temporizador_microondas
    import microondas_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int BEEP_SECS     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       clearn,
    input  logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       beep
);

    estado_t state_q;
    bcd_t    min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    bcd_t    min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
    logic    dec_zero;
    logic    tick;
    logic    key_accept;
    logic    count_en;
    logic [15:0] shifted;

    assign min_tens   = min_tens_q;
    assign min_ones   = min_ones_q;
    assign sec_tens   = sec_tens_q;
    assign sec_ones   = sec_ones_q;
    assign timer_done = ({min_tens_q, min_ones_q, sec_tens_q, sec_ones_q} == 16'h0000);

    assign key_accept = key_valid && (key_digit <= 4'd9) && !mag_on;
    assign shifted    = {min_ones_q, sec_tens_q, sec_ones_q, key_digit};
    // Counting starts on the edge that first samples mag_on, even from SET.
    assign count_en   = mag_on && clearn && (state_q != ST_IDLE);

    gerador_tick #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (count_en),
        .clr (!clearn),
        .tick(tick)
    );

    // One-second BCD decrement; entered seconds above 59 simply count down.
    always_comb begin
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        if (sec_ones_q != 4'd0) begin
            sec_ones_d = sec_ones_q - 4'd1;
        end else if (sec_tens_q != 4'd0) begin
            sec_tens_d = sec_tens_q - 4'd1;
            sec_ones_d = 4'd9;
        end else begin
            sec_tens_d = SEC_RELOAD_TENS;
            sec_ones_d = SEC_RELOAD_ONES;
            if (min_ones_q != 4'd0) begin
                min_ones_d = min_ones_q - 4'd1;
            end else begin
                min_ones_d = 4'd9;
                min_tens_d = min_tens_q - 4'd1;
            end
        end
        dec_zero = ({min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} == 16'h0000);
    end

`ifdef TEMPORIZADOR_BEEP_EN
    localparam int BEEP_CYCLES = BEEP_SECS * TICKS_PER_SEC;
    localparam int BW = $clog2(BEEP_CYCLES + 1);
    logic          beep_q;
    logic [BW-1:0] beep_cnt_q;
    assign beep = beep_q;
`else
    // BEEP_SECS only matters with the alarm compiled in.
    logic beep_cfg_unused;
    assign beep_cfg_unused = ^BEEP_SECS;
    assign beep = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            min_tens_q <= '0;
            min_ones_q <= '0;
            sec_tens_q <= '0;
            sec_ones_q <= '0;
`ifdef TEMPORIZADOR_BEEP_EN
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
`endif
        end else if (!clearn) begin
            state_q    <= ST_IDLE;
            min_tens_q <= '0;
            min_ones_q <= '0;
            sec_tens_q <= '0;
            sec_ones_q <= '0;
`ifdef TEMPORIZADOR_BEEP_EN
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
`endif
        end else if (key_accept) begin
            {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q} <= shifted;
            state_q <= (shifted != 16'h0000) ? ST_SET : ST_IDLE;
`ifdef TEMPORIZADOR_BEEP_EN
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
`endif
        end else if (tick) begin
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            state_q    <= dec_zero ? ST_IDLE : ST_RUN;
`ifdef TEMPORIZADOR_BEEP_EN
            if (dec_zero) begin
                beep_q     <= 1'b1;
                beep_cnt_q <= BW'(BEEP_CYCLES - 1);
            end
`endif
        end else begin
            case (state_q)
                ST_SET:  if (mag_on)  state_q <= ST_RUN;
                ST_RUN:  if (!mag_on) state_q <= ST_SET;
                default: state_q <= ST_IDLE;
            endcase
`ifdef TEMPORIZADOR_BEEP_EN
            if (beep_q) begin
                if (beep_cnt_q == '0) begin
                    beep_q <= 1'b0;
                end else begin
                    beep_cnt_q <= beep_cnt_q - 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_temporizador_microondas.sv
// tb/tb_temporizador_microondas.sv - directed self-checking bench for temporizador_microondas
module tb_temporizador_microondas;

    localparam int TPS  = 4;
    localparam int BSEC = 2;
`ifdef TEMPORIZADOR_BEEP_EN
    localparam logic BEEP_ON = 1'b1;
`else
    localparam logic BEEP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       clearn = 1'b1;
    logic       mag_on = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done, beep;

    int n_checks = 0;
    int n_pass   = 0;

    temporizador_microondas #(
        .TICKS_PER_SEC(TPS),
        .BEEP_SECS    (BSEC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .clearn    (clearn),
        .mag_on    (mag_on),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .timer_done(timer_done),
        .beep      (beep)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step(1);
        key_valid = 1'b0;
    endtask

    task automatic do_clear();
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
    endtask

    function automatic logic [15:0] disp();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    initial begin
        #1;
        check("reset_disp", disp(), 16'h0000);
        check("reset_done", {15'd0, timer_done}, 16'd1);
        check("reset_beep", {15'd0, beep}, 16'd0);
        step(2);
        rst = 1'b0;
        step(1);

        // Entry and invalid digit
        press(4'd1);
        check("key1_latency", disp(), 16'h0001);
        check("key1_done", {15'd0, timer_done}, 16'd0);
        press(4'd3);
        press(4'd0);
        check("entry_0130", disp(), 16'h0130);
        press(4'd12);
        check("bad_digit", disp(), 16'h0130);
        do_clear();
        check("clear_idle", disp(), 16'h0000);

        // Full countdown from 00:03
        press(4'd0); press(4'd0); press(4'd0); press(4'd3);
        check("entry_0003", disp(), 16'h0003);
        mag_on = 1'b1;
        step(3);
        check("before_first_tick", disp(), 16'h0003);
        step(1);
        check("tick1", disp(), 16'h0002);
        step(4);
        check("tick2", disp(), 16'h0001);
        step(4);
        check("tick3_zero", disp(), 16'h0000);
        check("zero_done", {15'd0, timer_done}, 16'd1);
        check("beep_start", {15'd0, beep}, {15'd0, BEEP_ON});
        step(7);
        check("beep_last", {15'd0, beep}, {15'd0, BEEP_ON});
        step(1);
        check("beep_end", {15'd0, beep}, 16'd0);
        check("idle_no_count", disp(), 16'h0000);
        mag_on = 1'b0;

        // Borrow cases
        press(4'd1); press(4'd0); press(4'd0);
        mag_on = 1'b1; step(4); mag_on = 1'b0;
        check("borrow_0100", disp(), 16'h0059);
        do_clear();
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        mag_on = 1'b1; step(4); mag_on = 1'b0;
        check("borrow_1000", disp(), 16'h0959);
        do_clear();
        press(4'd9); press(4'd0);
        mag_on = 1'b1; step(4); mag_on = 1'b0;
        check("borrow_0090", disp(), 16'h0089);
        do_clear();

        // Fifth digit discards the oldest
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        check("fifth_digit", disp(), 16'h2345);
        do_clear();

        // Pause keeps prescaler progress; key during RUN ignored
        press(4'd5);
        mag_on = 1'b1;
        step(6);
        check("pause_pre", disp(), 16'h0004);
        mag_on = 1'b0;
        step(5);
        check("pause_hold", disp(), 16'h0004);
        mag_on = 1'b1;
        step(1);
        check("resume_1", disp(), 16'h0004);
        press(4'd7);
        check("resume_tick_key_ignored", disp(), 16'h0003);
        step(3);
        mag_on = 1'b0;
        step(1);
        check("tick_dropped_on_fall", disp(), 16'h0003);
        mag_on = 1'b1;
        step(1);
        check("tick_after_resume", disp(), 16'h0002);
        mag_on = 1'b0;
        do_clear();

        // Clear mid-run
        press(4'd3); press(4'd0);
        mag_on = 1'b1;
        step(2);
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
        check("clear_run_disp", disp(), 16'h0000);
        check("clear_run_done", {15'd0, timer_done}, 16'd1);
        check("clear_run_beep", {15'd0, beep}, 16'd0);
        step(3);
        check("clear_beep_later", {15'd0, beep}, 16'd0);
        mag_on = 1'b0;

        // Asynchronous reset mid-count
        press(4'd3); press(4'd0);
        mag_on = 1'b1;
        step(2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_disp", disp(), 16'h0000);
        check("async_rst_done", {15'd0, timer_done}, 16'd1);
        check("async_rst_beep", {15'd0, beep}, 16'd0);
        step(1);
        rst = 1'b0;
        step(5);
        check("post_rst_idle", disp(), 16'h0000);
        mag_on = 1'b0;
        press(4'd4);
        check("post_rst_key", disp(), 16'h0004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/temporizador_microondas.md
# temporizador_microondas

Countdown timer for the microwave oven controller. It takes keypad digits, holds the cook time as MM:SS in BCD, and counts down once per second while the magnetron is on. It drives `timer_done`, which the magnetron control block consumes. It sits between the keypad encoder and the magnetron control block, and also feeds the 4-digit display.

## Interface
- TICKS_PER_SEC, default 1000: clk cycles per one-second tick; must be ≥2.
- BEEP_SECS, default 3: beep duration in seconds (used only with beep compiled in).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- key_valid  in  1  one-cycle strobe, keypad digit present.
- key_digit  in  4  BCD digit 0–9 accompanying key_valid.
- clearn  in  1  active-low clear button, sampled synchronously.
- mag_on  in  1  magnetron on; enables counting.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD display digits.
- timer_done  out  1  high whenever the time is 00:00.
- beep  out  1  end-of-cook alarm; constant 0 when beep is not compiled in.

## Operation
- FSM states:
  - IDLE: time 00:00.
  - SET: time ≠ 0, mag_on=0.
  - RUN: time ≠ 0, mag_on=1.
- Transitions:
  - IDLE→SET on an accepted nonzero entry.
  - SET→RUN when mag_on=1.
  - RUN→SET when mag_on=0 (pause).
  - RUN→IDLE when the time decrements to 00:00.
  - Any state→IDLE on clearn=0.
- Key entry is accepted only when key_valid=1, key_digit≤9, mag_on=0 and clearn=1.
  - Digits shift left: {min_tens,min_ones,sec_tens,sec_ones} ← {min_ones,sec_tens,sec_ones,key_digit}.
  - A fifth digit discards the old min_tens.
  - Digits >9 and keys pressed while mag_on=1 are ignored; the time is unchanged.
- The seconds field accepts 00–99 on entry (e.g. 01:90 is legal). The countdown handles it as follows:
  - sec_ones 0 borrows from sec_tens.
  - When seconds reach 00 and minutes ≠ 0, the next decrement gives minutes−1 and seconds=59.
  - Minutes borrow BCD-wise: 10:00 → 09:59.
- The prescaler counts 0..TICKS_PER_SEC−1 only in RUN with mag_on=1.
  - It holds its value while paused, so sub-second progress is kept.
  - It is zeroed on clear, on reaching 00:00, and on reset.
- `timer_done` is decoded from the digit registers only; there is no combinational path from the inputs.
- clearn=0 has priority over key entry and ticks. It zeroes the digits, the prescaler and beep.
- Reset values: all digits 0, prescaler 0, state IDLE, timer_done=1, beep=0.

## Timing
- Key accepted at edge N → new digits and timer_done visible after edge N. Latency is 1 cycle.
- mag_on rises with a fresh prescaler → the first decrement takes effect at edge TICKS_PER_SEC after mag_on is sampled high. Later decrements follow every TICKS_PER_SEC cycles.
- At the tick that produces 00:00, timer_done rises after that same edge.
- mag_on falling on a tick cycle: that tick is not applied.
- clearn=0 sampled at edge N → 00:00 and timer_done=1 after edge N, including mid-RUN.
- Reset asserted mid-count clears immediately, asynchronously. Deassertion takes effect at the next clk edge.
- mag_on=1 while in IDLE: no counting; timer_done stays 1.

## Configuration
- `TEMPORIZADOR_BEEP_EN` defined: on the RUN→IDLE transition caused by countdown, beep goes high for BEEP_SECS×TICKS_PER_SEC cycles.
  - A dedicated beep counter times this; the prescaler is not used.
  - clearn=0 or an accepted key ends the beep early.
  - The beep is not triggered by clear or reset.
- Macro not defined: beep is tied to 0 and no beep counter is built.

## Structure
- Shared package `microondas_pkg`:
  - state encoding (IDLE, SET, RUN)
  - 4-bit BCD digit type
  - constant SEC_RELOAD_TENS=5 and constant SEC_RELOAD_ONES=9
- One sub-module `gerador_tick`: the prescaler, with enable, synchronous clear, TICKS_PER_SEC parameter and a one-cycle `tick` output.
- The BCD down-count and the FSM stay in the top module.

## Test plan
All scenarios use TICKS_PER_SEC=4 and BEEP_SECS=2.
- Reset, then key strobes 1,3,0 → display 01:30, timer_done=0; key 12 → ignored, still 01:30.
- Keys 0,0,0,3, then mag_on=1 → 00:02 after 4 cycles, 00:01 after 8, and 00:00 with timer_done=1 after 12; state IDLE.
- Entry 01:00 with mag_on=1 for 4 cycles → 00:59. Entry 10:00 with one tick → 09:59. Entry 00:90 with one tick → 00:89.
- Running 00:05, mag_on=0 after 6 cycles (2 prescaler counts into the second second) → display 00:04 holds. mag_on=1 → 00:03 after 2 more cycles. Key 7 during RUN → ignored.
- Running 00:30, clearn=0 for one cycle → 00:00 and timer_done=1 on the next edge. Reset asserted mid-count → all outputs at reset values immediately.
- With TEMPORIZADOR_BEEP_EN: countdown reaching 00:00 → beep=1 for exactly 8 cycles. A clear from 00:30 → beep stays 0. Without the macro: beep=0 throughout.
